// File: rtl/auth_lut_pkg.sv
// Shared opcodes and payload sizing for the authorised-UID lookup table.
package auth_lut_pkg;

  localparam logic [7:0] CMD_CHECK  = 8'h10;
  localparam logic [7:0] CMD_ADD    = 8'h11;
  localparam logic [7:0] CMD_DELETE = 8'h12;

  localparam int unsigned UID_BYTES_MAX = 16;
  localparam int unsigned PAYLOAD_W     = 8 * UID_BYTES_MAX;

endpackage

// File: rtl/uid_slot_match.sv
// Combinational compare of one stored UID against the command payload.
module uid_slot_match
  import auth_lut_pkg::*;
#(
  parameter int unsigned UID_LEN = 4
) (
  input  logic                   i_slot_valid,
  input  logic                   i_len_ok,
  input  logic [8*UID_LEN-1:0]   i_stored,
  input  logic [PAYLOAD_W-1:0]   i_payload,
  output logic                   o_hit
);

  localparam logic [PAYLOAD_W-1:0] CMP_MASK = {PAYLOAD_W{1'b1}} >> (PAYLOAD_W - 8 * UID_LEN);

  logic [PAYLOAD_W-1:0] w_diff;

  // Bytes past UID_LEN are masked so trailing payload never affects a match.
  assign w_diff = (i_payload ^ PAYLOAD_W'(i_stored)) & CMP_MASK;
  assign o_hit  = i_slot_valid & i_len_ok & (w_diff == '0);

endmodule

// File: rtl/uid_auth_lut.sv
// Authorised-UID table: CHECK/ADD with registered result flags.
// Define AUTH_LUT_DELETE_EN to support the DELETE opcode.
module uid_auth_lut
  import auth_lut_pkg::*;
#(
  parameter int unsigned UID_MAX = 4,
  parameter int unsigned UID_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           cmd,
  input  logic                 valid,
  input  logic [PAYLOAD_W-1:0] uid_bytes_flat,
  input  logic [7:0]           uid_len,
  output logic                 uid_allowed,
  output logic                 uid_added_ok,
  output logic                 uid_duplicate,
  output logic                 uid_full
);

  logic [UID_MAX-1:0]   r_valid;
  logic [8*UID_LEN-1:0] r_data [UID_MAX];

  logic                 w_len_ok;
  logic [UID_MAX-1:0]   w_hit;
  logic                 w_any_hit;
  logic [UID_MAX-1:0]   w_free_oh;
  logic                 w_full;
  logic [UID_MAX-1:0]   w_valid_d;
  logic [UID_MAX-1:0]   w_wr_oh;
  logic                 w_allowed_d;
  logic                 w_added_d;
  logic                 w_dup_d;
  logic                 w_full_d;

  assign w_len_ok  = (uid_len == 8'(UID_LEN));
  assign w_any_hit = |w_hit;
  assign w_full    = &r_valid;

  for (genvar k = 0; k < UID_MAX; k++) begin : g_slot
    uid_slot_match #(
      .UID_LEN (UID_LEN)
    ) u_match (
      .i_slot_valid (r_valid[k]),
      .i_len_ok     (w_len_ok),
      .i_stored     (r_data[k]),
      .i_payload    (uid_bytes_flat),
      .o_hit        (w_hit[k])
    );
  end

  // Lowest-index free slot, one-hot; all zero when the table is full.
  always_comb begin
    w_free_oh = '0;
    for (int k = UID_MAX - 1; k >= 0; k--) begin
      if (!r_valid[k]) begin
        w_free_oh    = '0;
        w_free_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_allowed_d = 1'b0;
    w_added_d   = 1'b0;
    w_dup_d     = 1'b0;
    w_full_d    = 1'b0;
    w_valid_d   = r_valid;
    w_wr_oh     = '0;
    case (cmd)
      CMD_CHECK: w_allowed_d = w_any_hit;
      CMD_ADD: begin
        if (w_len_ok) begin
          if (w_any_hit) begin
            w_dup_d = 1'b1;
          end else if (w_full) begin
            w_full_d = 1'b1;
          end else begin
            w_added_d = 1'b1;
            w_wr_oh   = w_free_oh;
            w_valid_d = r_valid | w_free_oh;
          end
        end
      end
`ifdef AUTH_LUT_DELETE_EN
      CMD_DELETE: begin
        if (w_any_hit) begin
          w_allowed_d = 1'b1;
          w_valid_d   = r_valid & ~w_hit;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid       <= '0;
      uid_allowed   <= 1'b0;
      uid_added_ok  <= 1'b0;
      uid_duplicate <= 1'b0;
      uid_full      <= 1'b0;
    end else if (valid) begin
      r_valid       <= w_valid_d;
      uid_allowed   <= w_allowed_d;
      uid_added_ok  <= w_added_d;
      uid_duplicate <= w_dup_d;
      uid_full      <= w_full_d;
    end
  end

  // Stored bytes need no reset: a slot is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < UID_MAX; k++) begin
      if (rst_n && valid && w_wr_oh[k]) begin
        r_data[k] <= uid_bytes_flat[8*UID_LEN-1:0];
      end
    end
  end

endmodule

// File: tb/tb_uid_auth_lut.sv
// Bench for uid_auth_lut: directed table, corner sequences, random vs. reference model.
module tb_uid_auth_lut;

  logic         clk;
  logic         rst_n;
  logic [7:0]   cmd;
  logic         valid;
  logic [127:0] uid_bytes_flat;
  logic [7:0]   uid_len;
  logic         uid_allowed;
  logic         uid_added_ok;
  logic         uid_duplicate;
  logic         uid_full;

  int n_vec;
  int n_bad;

  uid_auth_lut #(
    .UID_MAX (4),
    .UID_LEN (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd            (cmd),
    .valid          (valid),
    .uid_bytes_flat (uid_bytes_flat),
    .uid_len        (uid_len),
    .uid_allowed    (uid_allowed),
    .uid_added_ok   (uid_added_ok),
    .uid_duplicate  (uid_duplicate),
    .uid_full       (uid_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: a set of up to 4 UIDs held in slot order.
  bit [31:0] m_uid [4];
  bit        m_v   [4];

  function automatic logic [3:0] flags();
    return {uid_allowed, uid_added_ok, uid_duplicate, uid_full};
  endfunction

  // Byte 0 of the payload is the most significant byte of the 32-bit literal.
  function automatic logic [127:0] mk(input logic [31:0] u, input logic [95:0] junk);
    return {junk, u[7:0], u[15:8], u[23:16], u[31:24]};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_v[k] = 1'b0;
  endfunction

  // Result flags are {allowed, added_ok, duplicate, full}.
  function automatic logic [3:0] model_step(input logic [7:0] c, input logic [127:0] p,
                                            input logic [7:0] l);
    int hit;
    int free;
    hit = -1;
    if (l == 8'd4)
      for (int k = 0; k < 4; k++) if (m_v[k] && m_uid[k] == p[31:0]) hit = k;
    case (c)
      8'h10: return (hit >= 0) ? 4'b1000 : 4'b0000;
      8'h11: begin
        if (l != 8'd4) return 4'b0000;
        if (hit >= 0) return 4'b0010;
        free = -1;
        for (int k = 3; k >= 0; k--) if (!m_v[k]) free = k;
        if (free < 0) return 4'b0001;
        m_v[free]   = 1'b1;
        m_uid[free] = p[31:0];
        return 4'b0100;
      end
`ifdef AUTH_LUT_DELETE_EN
      8'h12: begin
        if (hit < 0) return 4'b0000;
        m_v[hit] = 1'b0;
        return 4'b1000;
      end
`endif
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: flags got %b expected %b", name, got, exp);
    end
  endtask

  // Issue one command; valid stays high so back-to-back calls are consecutive commands.
  task automatic send(input logic [7:0] c, input logic [127:0] p, input logic [7:0] l,
                      output logic [3:0] got, output logic [3:0] exp);
    @(negedge clk);
    cmd            = c;
    uid_bytes_flat = p;
    uid_len        = l;
    valid          = 1'b1;
    @(posedge clk);
    #1;
    got = flags();
    exp = model_step(c, p, l);
  endtask

  task automatic send_chk(input string name, input logic [7:0] c, input logic [31:0] u,
                          input logic [7:0] l, input logic [3:0] exp_fixed);
    logic [3:0] got, exp;
    send(c, mk(u, 96'h0), l, got, exp);
    check(name, got, exp_fixed);
  endtask

  task automatic idle_hold(input string name, input int n, input logic [3:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0;
      cmd   = 8'h10;
      @(posedge clk);
      #1;
      check(name, flags(), exp);
    end
  endtask

  typedef struct {
    logic [7:0]  c;
    logic [31:0] u;
    logic [7:0]  l;
    logic [3:0]  exp;
    string       name;
  } vec_t;

  vec_t       tbl [$];
  bit [31:0]  pool [6];
  logic [3:0] got, exp;

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    valid          = 1'b0;
    cmd            = 8'h00;
    uid_bytes_flat = '0;
    uid_len        = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", flags(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{8'h10, 32'hDEADBEEF, 8'd4, 4'b0000, "check_empty"});
    tbl.push_back('{8'h11, 32'hDEADBEEF, 8'd4, 4'b0100, "add_first"});
    tbl.push_back('{8'h10, 32'hDEADBEEF, 8'd4, 4'b1000, "check_after_add"});
    tbl.push_back('{8'h11, 32'hDEADBEEF, 8'd4, 4'b0010, "readd_dup"});
    tbl.push_back('{8'h11, 32'h01020304, 8'd4, 4'b0100, "add_2"});
    tbl.push_back('{8'h11, 32'h05060708, 8'd4, 4'b0100, "add_3"});
    tbl.push_back('{8'h11, 32'h090A0B0C, 8'd4, 4'b0100, "add_4"});
    tbl.push_back('{8'h11, 32'h11223344, 8'd4, 4'b0001, "add_full"});
    tbl.push_back('{8'h11, 32'h05060708, 8'd4, 4'b0010, "dup_over_full"});
    tbl.push_back('{8'h10, 32'hDEADBEEF, 8'd3, 4'b0000, "check_len3"});
    tbl.push_back('{8'h11, 32'h11223344, 8'd5, 4'b0000, "add_len5"});
    tbl.push_back('{8'h10, 32'h11223344, 8'd4, 4'b0000, "len5_not_stored"});
    tbl.push_back('{8'h10, 32'h090A0B0C, 8'd4, 4'b1000, "check_last"});
    tbl.push_back('{8'h55, 32'hDEADBEEF, 8'd4, 4'b0000, "bad_opcode_clears"});
    foreach (tbl[i]) send_chk(tbl[i].name, tbl[i].c, tbl[i].u, tbl[i].l, tbl[i].exp);

    // Flags hold across idle cycles, then an unsupported opcode clears them.
    send_chk("dup_before_hold", 8'h11, 32'h01020304, 8'd4, 4'b0010);
    idle_hold("hold_idle", 10, 4'b0010);
    send_chk("bad_opcode_after_hold", 8'h55, 32'h01020304, 8'd4, 4'b0000);

`ifdef AUTH_LUT_DELETE_EN
    send_chk("delete_hit", 8'h12, 32'h01020304, 8'd4, 4'b1000);
    send_chk("check_deleted", 8'h10, 32'h01020304, 8'd4, 4'b0000);
    send_chk("delete_miss", 8'h12, 32'h01020304, 8'd4, 4'b0000);
    send_chk("add_into_freed", 8'h11, 32'h11223344, 8'd4, 4'b0100);
    send_chk("full_again", 8'h11, 32'h55667788, 8'd4, 4'b0001);
`else
    send_chk("delete_unsupported", 8'h12, 32'h01020304, 8'd4, 4'b0000);
    send_chk("check_not_deleted", 8'h10, 32'h01020304, 8'd4, 4'b1000);
`endif

    // Reset mid-sequence discards the coincident command and empties the table.
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_clears", flags(), 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_chk("post_rst_add_a", 8'h11, 32'hAAAA0001, 8'd4, 4'b0100);
    send_chk("post_rst_add_b", 8'h11, 32'hBBBB0002, 8'd4, 4'b0100);
    @(negedge clk);
    rst_n          = 1'b0;
    cmd            = 8'h11;
    uid_bytes_flat = mk(32'hCCCC0003, 96'h0);
    uid_len        = 8'd4;
    valid          = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_flags", flags(), 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    send_chk("check_a_after_rst", 8'h10, 32'hAAAA0001, 8'd4, 4'b0000);
    send_chk("check_c_discarded", 8'h10, 32'hCCCC0003, 8'd4, 4'b0000);

    // Random traffic against the reference model; upper payload bytes carry junk.
    pool = '{32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'hCAFEF00D, 32'h0BADBEEF, 32'h87654321};
    for (int i = 0; i < 400; i++) begin
      logic [7:0]   c;
      logic [7:0]   l;
      logic [127:0] p;
      int           r;
      r = int'($urandom_range(0, 9));
      c = (r < 4) ? 8'h11 : (r < 7) ? 8'h10 : (r < 9) ? 8'h12 : 8'($urandom);
      l = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 8)) : 8'd4;
      p = mk(pool[$urandom_range(0, 5)], {$urandom, $urandom, $urandom});
      send(c, p, l, got, exp);
      check("random", got, exp);
      if ($urandom_range(0, 7) == 0) idle_hold("random_hold", int'($urandom_range(1, 3)), exp);
    end

    @(negedge clk);
    valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
